// File: rtl/grasspopper_stream_feeder_if.sv
// Handshake and data bundle between the stream feeder, its upstream/downstream
// word streams and the 128-bit cipher core.
interface grasspopper_stream_feeder_if;
  logic [31:0]  s_data_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [127:0] core_data_o;
  logic         core_req_o;
  logic         core_ack_o;
  logic [127:0] core_data_i;
  logic         core_valid_i;
  logic         core_busy_i;
  logic [31:0]  m_data_o;
  logic         m_valid_o;
  logic         m_ready_i;
  logic         err_clr_i;
  logic         err_o;
  logic [15:0]  blk_cnt_o;

  // Feeder view
  modport master (
    input  s_data_i, s_valid_i, core_data_i, core_valid_i, core_busy_i,
           m_ready_i, err_clr_i,
    output s_ready_o, core_data_o, core_req_o, core_ack_o, m_data_o,
           m_valid_o, err_o, blk_cnt_o
  );

  // Environment view (sources, core and sink)
  modport slave (
    output s_data_i, s_valid_i, core_data_i, core_valid_i, core_busy_i,
           m_ready_i, err_clr_i,
    input  s_ready_o, core_data_o, core_req_o, core_ack_o, m_data_o,
           m_valid_o, err_o, blk_cnt_o
  );
endinterface

// File: rtl/grasspopper_stream_feeder.sv
// Packs 32-bit input words into 128-bit blocks for a cipher core and streams
// the 128-bit results back out as 32-bit words, with a per-wait-state timeout.
module grasspopper_stream_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                         pclk_i,
  input logic                         presetn_i,
  grasspopper_stream_feeder_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_VAL, ACK} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [127:0]   ib_data;
  logic [2:0]     ib_cnt;
  logic [2:0]     ib_cnt_nxt;
  logic           s_ready;
  logic [127:0]   ob_data;
  logic [2:0]     ob_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           err;
  logic [15:0]    blk_cnt;
  logic           in_fire;
  logic           out_fire;
  logic           tmo_expired;
  logic           clr_ib;
  logic           capture;
  logic           tmo_hit;
  logic           blk_done;

  assign in_fire     = bus.s_valid_i & s_ready;
  assign out_fire    = (ob_cnt != 3'd0) & bus.m_ready_i;
  assign tmo_expired = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // A busy/valid arriving on the same edge as the timeout wins over the abort.
  always_comb begin
    state_nxt = state;
    clr_ib    = 1'b0;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    blk_done  = 1'b0;
    case (state)
      IDLE: begin
        if (ib_cnt == 3'd4 && ob_cnt == 3'd0) state_nxt = REQ;
      end
      REQ: begin
        if (bus.core_busy_i) begin
          state_nxt = WAIT_VAL;
          clr_ib    = 1'b1;
        end else if (tmo_expired) begin
          state_nxt = IDLE;
          clr_ib    = 1'b1;
          tmo_hit   = 1'b1;
        end
      end
      WAIT_VAL: begin
        if (bus.core_valid_i) begin
          state_nxt = ACK;
          capture   = 1'b1;
        end else if (tmo_expired) begin
          state_nxt = IDLE;
          clr_ib    = 1'b1;
          tmo_hit   = 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        blk_done  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i)              tmo_cnt <= '0;
    else if (state_nxt != state) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_comb begin
    ib_cnt_nxt = ib_cnt;
    if (clr_ib)       ib_cnt_nxt = 3'd0;
    else if (in_fire) ib_cnt_nxt = ib_cnt + 3'd1;
  end

  // s_ready is registered from the next fill level so it never lags a fill.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      ib_data <= '0;
      ib_cnt  <= 3'd0;
      s_ready <= 1'b0;
    end else begin
      ib_cnt  <= ib_cnt_nxt;
      s_ready <= (ib_cnt_nxt < 3'd4);
      if (in_fire && !clr_ib) ib_data[{ib_cnt[1:0], 5'd0} +: 32] <= bus.s_data_i;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      ob_data <= '0;
      ob_cnt  <= 3'd0;
    end else if (capture) begin
      ob_data <= bus.core_data_i;
      ob_cnt  <= 3'd4;
    end else if (out_fire) begin
      ob_data <= {32'h0, ob_data[127:32]};
      ob_cnt  <= ob_cnt - 3'd1;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      err     <= 1'b0;
      blk_cnt <= 16'd0;
    end else begin
      if (tmo_hit)            err <= 1'b1;
      else if (bus.err_clr_i) err <= 1'b0;
      if (blk_done) blk_cnt <= blk_cnt + 16'd1;
    end
  end

  assign bus.s_ready_o   = s_ready;
  assign bus.core_data_o = ib_data;
  assign bus.core_req_o  = (state == REQ);
  assign bus.core_ack_o  = (state == ACK);
  assign bus.m_data_o    = ob_data[31:0];
  assign bus.m_valid_o   = (ob_cnt != 3'd0);
  assign bus.err_o       = err;
  assign bus.blk_cnt_o   = blk_cnt;

endmodule
